// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional early termination is enabled by defining SEQ_MUL_EARLY_TERM_EN.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough to hold A_W itself, the value cnt reaches after the final step.
  function automatic int cnt_width(input int a_w);
    return (a_w < 1) ? 1 : $clog2(a_w + 1);
  endfunction

endpackage

// File: rtl/mul_ripple_adder.sv
// W-bit ripple-carry adder built from a chain of full-adder cells.
module mul_ripple_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum[gi]         = a[gi] ^ b[gi] ^ carry_s[gi];
    assign carry_s[gi + 1] = (a[gi] & b[gi]) | (carry_s[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned multi-cycle multiplier: one shift-add step per clock, valid/ready on both sides.
// Defining SEQ_MUL_EARLY_TERM_EN finishes as soon as the unscanned multiplier bits are zero.
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int A_W = 3,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product,
  output logic               busy
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = cnt_width(A_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(A_W - 1);

  state_e           state_q, state_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [B_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, busy_q, out_valid_q;
  logic [P_W-1:0]   product_q;

  logic [B_W-1:0]   addend_s;
  logic [B_W-1:0]   sum_s;
  logic             cout_s;
  logic [P_W-1:0]   step_s;

  assign addend_s = acc_q[0] ? mcand_q : {B_W{1'b0}};

  mul_ripple_adder #(.W(B_W)) u_adder (
    .a    (acc_q[P_W-1:A_W]),
    .b    (addend_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Carry enters the MSB while the accumulator shifts right by one.
  if (A_W == 1) begin : g_step_1
    assign step_s = {cout_s, sum_s};
  end else begin : g_step_n
    assign step_s = {cout_s, sum_s, acc_q[A_W-1:1]};
  end

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [CNT_W-1:0] rem_s;
  logic [P_W-1:0]   rem_mask_s;
  logic             early_s;
  logic [P_W-1:0]   aligned_s;

  // Remaining steps would only shift zeros in, so one barrel shift finishes them.
  assign rem_s      = LAST - cnt_q;
  assign rem_mask_s = (P_W'(1) << rem_s) - P_W'(1);
  assign early_s    = (rem_s != {CNT_W{1'b0}}) && ((step_s & rem_mask_s) == {P_W{1'b0}});
  assign aligned_s  = step_s >> rem_s;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d = b;
          acc_d   = {{B_W{1'b0}}, a};
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
`ifdef SEQ_MUL_EARLY_TERM_EN
          if (early_s) begin
            acc_d   = aligned_s;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change in step with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {P_W{1'b0}};
      mcand_q     <= {B_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= {P_W{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == RUN);
      out_valid_q <= (state_d == DONE);
      product_q   <= (state_d == DONE) ? acc_d : {P_W{1'b0}};
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
